// File: rtl/fetch_flow_controller.sv
// fetch_flow_controller
//   Sequencing FSM for the instruction-fetch stage. Decides, cycle by cycle,
//   when the PC is frozen and when it is redirected (jump target, interrupt
//   vector, call target, popped return address), and drives the two 16-bit
//   stack-transfer phases that move the 32-bit PC to/from the data stack.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   intr_req          external INTR level (rising edge detected internally)
//   call_dec, ret_dec, rti_dec, jump_taken   one-cycle event pulses
//   imm_fetch         current fetch word carries an immediate
//   mem_busy          memory stage owns the data memory this cycle
//   freeze_pc .. intr_ack   Moore strobes toward the PC/stack logic
//   state_dbg         current FSM state, for observation only
//
// Strobe semantics: there is no valid/ready handshake. Every input event is
// a one-cycle pulse sampled only in IDLE; every output is a registered decode
// of the FSM state, valid for exactly the cycles the FSM spends in that state.
module fetch_flow_controller #(
  parameter int DRAIN_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       intr_req,
  input  logic       call_dec,
  input  logic       ret_dec,
  input  logic       rti_dec,
  input  logic       jump_taken,
  input  logic       imm_fetch,
  input  logic       mem_busy,
  output logic       freeze_pc,
  output logic       flush_fd,
  output logic       pc_to_stack,
  output logic       push_half,
  output logic       pop_req,
  output logic       write_popped_pc,
  output logic       take_intr,
  output logic       take_call,
  output logic       stall_jump,
  output logic       flags_restore,
  output logic       intr_ack,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    IDLE, JUMP, DRAIN, PUSH_L, PUSH_H, VEC,
    CALL_L, CALL_H, CALL_GO, POP_H, POP_L, POP_LOAD
  } state_t;

  localparam int CW = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_MAX - 1);

  state_t          state;
  state_t          next_state;
  logic            next_is_rti;
  logic            intr_q;
  logic            pending;
  logic            is_rti;
  logic [CW-1:0]   drain_cnt;

  assign state_dbg = state;

  always_comb begin
    next_state  = state;
    next_is_rti = is_rti;
    case (state)
      IDLE: begin
        if (ret_dec || rti_dec) begin
          next_state  = POP_H;
          next_is_rti = rti_dec;
        end else if (call_dec) begin
          next_state = CALL_L;
        end else if (jump_taken) begin
          next_state = JUMP;
        end else if (pending && !imm_fetch) begin
          // Never break an instruction from its immediate word.
          next_state = DRAIN;
        end
      end
      JUMP:     next_state = IDLE;
      // Wait for the data memory, but never longer than DRAIN_MAX cycles.
      DRAIN:    if (!mem_busy || drain_cnt == DRAIN_LAST) next_state = PUSH_L;
      PUSH_L:   next_state = PUSH_H;
      PUSH_H:   next_state = VEC;
      VEC:      next_state = IDLE;
      CALL_L:   next_state = CALL_H;
      CALL_H:   next_state = CALL_GO;
      CALL_GO:  next_state = IDLE;
      POP_H:    next_state = POP_L;
      POP_L:    next_state = POP_LOAD;
      POP_LOAD: next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state, so each one equals a decode of
  // the state register while never seeing an input combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      intr_q          <= 1'b0;
      pending         <= 1'b0;
      is_rti          <= 1'b0;
      drain_cnt       <= '0;
      freeze_pc       <= 1'b0;
      flush_fd        <= 1'b0;
      pc_to_stack     <= 1'b0;
      push_half       <= 1'b0;
      pop_req         <= 1'b0;
      write_popped_pc <= 1'b0;
      take_intr       <= 1'b0;
      take_call       <= 1'b0;
      stall_jump      <= 1'b0;
      flags_restore   <= 1'b0;
      intr_ack        <= 1'b0;
    end else begin
      state  <= next_state;
      is_rti <= next_is_rti;
      intr_q <= intr_req;

      // Clear on VEC entry wins: an edge arriving then is absorbed.
      if (next_state == VEC)             pending <= 1'b0;
      else if (intr_req && !intr_q)      pending <= 1'b1;

      if (state == DRAIN && next_state == DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else                                       drain_cnt <= '0;

      freeze_pc       <= next_state inside {DRAIN, PUSH_L, PUSH_H, CALL_L,
                                            CALL_H, POP_H, POP_L};
      flush_fd        <= (next_state != IDLE);
      pc_to_stack     <= next_state inside {PUSH_L, PUSH_H, CALL_L, CALL_H};
      push_half       <= next_state inside {PUSH_H, CALL_H, POP_H};
      pop_req         <= next_state inside {POP_H, POP_L};
      write_popped_pc <= (next_state == POP_LOAD);
      take_intr       <= (next_state == VEC);
      take_call       <= (next_state == CALL_GO);
      stall_jump      <= (next_state == JUMP);
      flags_restore   <= (next_state == POP_LOAD) && next_is_rti;
      intr_ack        <= (next_state == VEC);
    end
  end

endmodule

// File: tb/tb_fetch_flow_controller.sv
// Testbench for fetch_flow_controller: directed scenarios followed by random
// event traffic, checked cycle by cycle against a plan-queue reference model.
module tb_fetch_flow_controller;

  localparam int DRAIN_MAX = 4;
  localparam int W = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b1;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic intr_req = 0, call_dec = 0, ret_dec = 0, rti_dec = 0;
  logic jump_taken = 0, imm_fetch = 0, mem_busy = 0;
  logic freeze_pc, flush_fd, pc_to_stack, push_half, pop_req;
  logic write_popped_pc, take_intr, take_call, stall_jump, flags_restore, intr_ack;
  logic [3:0] state_dbg;

  fetch_flow_controller #(.DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .rst(rst),
    .intr_req(intr_req), .call_dec(call_dec), .ret_dec(ret_dec),
    .rti_dec(rti_dec), .jump_taken(jump_taken), .imm_fetch(imm_fetch),
    .mem_busy(mem_busy),
    .freeze_pc(freeze_pc), .flush_fd(flush_fd), .pc_to_stack(pc_to_stack),
    .push_half(push_half), .pop_req(pop_req), .write_popped_pc(write_popped_pc),
    .take_intr(take_intr), .take_call(take_call), .stall_jump(stall_jump),
    .flags_restore(flags_restore), .intr_ack(intr_ack), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;
  int cycle_no = 0;
  int dut_acks = 0;
  bit mon_en = 0;

  // ---------------- reference model ----------------
  // The model keeps a queue of upcoming sequence steps; an empty queue is idle.
  typedef enum int {S_JUMP, S_DRAIN, S_PUSH_L, S_PUSH_H, S_VEC, S_CALL_L,
                    S_CALL_H, S_CALL_GO, S_POP_H, S_POP_L, S_POP_LOAD} step_t;
  step_t plan[$];
  bit m_pending = 0, m_intr_q = 0, m_is_rti = 0;
  int m_drain = 0;
  int m_acks = 0;

  // Bit order: freeze, flush, pc_to_stack, push_half, pop_req, write_popped,
  // take_intr, take_call, stall_jump, flags_restore, intr_ack
  function automatic logic [W-1:0] step_outputs(bit active, step_t s, bit rti);
    logic fz, fl, pts, ph, pop, wp, ti, tc, sj, fr, ack;
    {fz, fl, pts, ph, pop, wp, ti, tc, sj, fr, ack} = '0;
    if (active) begin
      case (s)
        S_JUMP:             begin sj = 1; fl = 1; end
        S_DRAIN:            begin fz = 1; fl = 1; end
        S_PUSH_L, S_CALL_L: begin pts = 1; fz = 1; fl = 1; end
        S_PUSH_H, S_CALL_H: begin pts = 1; ph = 1; fz = 1; fl = 1; end
        S_VEC:              begin ti = 1; ack = 1; fl = 1; end
        S_CALL_GO:          begin tc = 1; fl = 1; end
        S_POP_H:            begin pop = 1; ph = 1; fz = 1; fl = 1; end
        S_POP_L:            begin pop = 1; fz = 1; fl = 1; end
        S_POP_LOAD:         begin wp = 1; fl = 1; fr = rti; end
        default:            ;
      endcase
    end
    return {fz, fl, pts, ph, pop, wp, ti, tc, sj, fr, ack};
  endfunction

  // Advance the model by one clock edge using the inputs currently driven,
  // and queue the outputs expected after that edge.
  task automatic model_step();
    bit rise;
    if (!rst) begin
      plan.delete();
      m_pending = 0; m_intr_q = 0; m_is_rti = 0; m_drain = 0;
      exp_q.push_back('0);
      return;
    end
    rise = intr_req && !m_intr_q;
    if (plan.size() == 0) begin
      if (ret_dec || rti_dec) begin
        m_is_rti = rti_dec;
        plan.push_back(S_POP_H); plan.push_back(S_POP_L); plan.push_back(S_POP_LOAD);
      end else if (call_dec) begin
        plan.push_back(S_CALL_L); plan.push_back(S_CALL_H); plan.push_back(S_CALL_GO);
      end else if (jump_taken) begin
        plan.push_back(S_JUMP);
      end else if (m_pending && !imm_fetch) begin
        m_drain = 0;
        plan.push_back(S_DRAIN); plan.push_back(S_PUSH_L);
        plan.push_back(S_PUSH_H); plan.push_back(S_VEC);
      end
    end else if (plan[0] == S_DRAIN) begin
      m_drain++;
      if (!mem_busy || m_drain == DRAIN_MAX) void'(plan.pop_front());
    end else begin
      void'(plan.pop_front());
    end
    if (plan.size() > 0 && plan[0] == S_VEC) begin
      m_pending = 0;
      m_acks++;
    end else if (rise) begin
      m_pending = 1;
    end
    m_intr_q = intr_req;
    exp_q.push_back(plan.size() > 0 ? step_outputs(1, plan[0], m_is_rti)
                                    : step_outputs(0, S_JUMP, 0));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic i_intr, input logic i_call, input logic i_ret,
                       input logic i_rti, input logic i_jump, input logic i_imm,
                       input logic i_busy, input logic i_rst);
    @(negedge clk);
    intr_req = i_intr; call_dec = i_call; ret_dec = i_ret; rti_dec = i_rti;
    jump_taken = i_jump; imm_fetch = i_imm; mem_busy = i_busy; rst = i_rst;
    model_step();
    mon_en = 1;
  endtask

  task automatic idle(input logic i_intr, input int n);
    for (int k = 0; k < n; k++) drive(i_intr, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] act, e;
    forever begin
      @(posedge clk);
      #1;
      cycle_no++;
      if (mon_en) begin
        act = {freeze_pc, flush_fd, pc_to_stack, push_half, pop_req, write_popped_pc,
               take_intr, take_call, stall_jump, flags_restore, intr_ack};
        dut_acks += int'(intr_ack);
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL scoreboard_underflow cycle %0d: got outputs %b, no expectation queued",
                   cycle_no, act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            fails++;
            $display("FAIL outputs cycle %0d: got %b expected %b (state_dbg=%0d)",
                     cycle_no, act, e, state_dbg);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    // Reset
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 2);

    // Interrupt with memory idle
    idle(1, 7);
    idle(0, 2);

    // Interrupt held off by an immediate fetch for two cycles
    drive(1, 0, 0, 0, 0, 1, 0, 1);
    drive(1, 0, 0, 0, 0, 1, 0, 1);
    drive(1, 0, 0, 0, 0, 1, 0, 1);
    idle(1, 6);
    idle(0, 2);

    // Interrupt with memory stuck busy
    drive(1, 0, 0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 9; k++) drive(1, 0, 0, 0, 0, 0, 1, 1);
    idle(0, 3);

    // Call and interrupt edge in the same cycle
    drive(1, 1, 0, 0, 0, 0, 0, 1);
    idle(1, 10);
    idle(0, 2);

    // RTI then RET
    drive(0, 0, 0, 1, 0, 0, 0, 1);
    idle(0, 4);
    drive(0, 0, 1, 0, 0, 0, 0, 1);
    idle(0, 4);

    // Jump, then a jump arriving during POP_L that must be ignored
    drive(0, 0, 0, 0, 1, 0, 0, 1);
    idle(0, 2);
    drive(0, 0, 0, 1, 0, 0, 0, 1);
    idle(0, 1);
    drive(0, 0, 0, 0, 1, 0, 0, 1);
    idle(0, 4);

    // Reset asserted while in PUSH_H
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    guard = 0;
    while (!(plan.size() > 0 && plan[0] == S_PUSH_H) && guard < 20) begin
      drive(1, 0, 0, 0, 0, 0, 0, 1);
      guard++;
    end
    tests++;
    if (guard >= 20) begin
      fails++;
      $display("FAIL reach_push_h: got %0d cycles waited, required < 20", guard);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 8);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      logic r_intr, r_call, r_ret, r_rti, r_jump, r_imm, r_busy, r_rst;
      int r;
      r = $urandom_range(0, 99);
      r_call = (r < 6);
      r_ret  = (r >= 6 && r < 10);
      r_rti  = (r >= 10 && r < 13);
      r_jump = (r >= 13 && r < 20) || ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 19) == 0) r_call = 1;
      r_intr = ($urandom_range(0, 7) == 0) ? ~intr_req : intr_req;
      r_imm  = ($urandom_range(0, 2) == 0);
      r_busy = ($urandom_range(0, 1) == 0);
      r_rst  = ($urandom_range(0, 199) != 0);
      drive(r_intr, r_call, r_ret, r_rti, r_jump, r_imm, r_busy, r_rst);
    end
    idle(0, 12);

    // Let the monitor consume the last expectation
    @(posedge clk);
    #2;
    mon_en = 0;

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d leftover expectations, required 0", exp_q.size());
    end
    tests++;
    if (dut_acks != m_acks) begin
      fails++;
      $display("FAIL intr_ack_count: got %0d acks, required %0d", dut_acks, m_acks);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
